// File: rtl/overlay_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : overlay_bank_ctrl
//  Description : Ping-pong controller for the centred WIDTH x HEIGHT RGB
//                overlay image. Two 24-bit pixel banks: the loader streams a
//                raster-ordered image into the back bank while the display
//                reads the front bank. The banks swap only on a frame-start
//                pulse, and only once the back bank holds a complete image,
//                so the display never shows a partially written image.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    OVL_LEN_CHECK_EN - when defined, iWR_LAST must mark exactly pixel
//                       NPIX-1 of each image. A mismatch pulses oERR and
//                       discards the image. When undefined, iWR_LAST is
//                       ignored, oERR is tied low and an image completes
//                       purely on a count of NPIX accepted pixels.
// ----------------------------------------------------------------------------
//  Ports:
//    iCLK          in   1   pixel clock, rising edge
//    iRST          in   1   asynchronous active-high reset
//    iWR_VALID     in   1   loader pixel valid
//    iWR_DATA      in   24  loader pixel {R,G,B}
//    iWR_LAST      in   1   final pixel of an image
//    oWR_READY     out  1   controller accepts a pixel this cycle
//    iFRAME_START  in   1   one-cycle pulse at display vertical blank
//    iRD_ADDR      in   AW  display read address, y*WIDTH+x
//    oRD_DATA      out  24  front-bank pixel, one cycle after iRD_ADDR
//    oFRONT_BANK   out  1   index of the bank being displayed
//    oSWAP         out  1   one-cycle pulse after a bank swap
//    oPENDING      out  1   back bank full, waiting for a frame start
//    oERR          out  1   one-cycle pulse on an image length error
// ============================================================================
module overlay_bank_ctrl #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int NPIX   = WIDTH * HEIGHT,
  parameter int AW     = 7
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iWR_VALID,
  input  logic [23:0]   iWR_DATA,
  input  logic          iWR_LAST,
  output logic          oWR_READY,
  input  logic          iFRAME_START,
  input  logic [AW-1:0] iRD_ADDR,
  output logic [23:0]   oRD_DATA,
  output logic          oFRONT_BANK,
  output logic          oSWAP,
  output logic          oPENDING,
  output logic          oERR
);

  localparam logic [0:0]    S_FILL   = 1'b0;
  localparam logic [0:0]    S_PEND   = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_EXT = (AW + 1)'(NPIX);

  // Elaboration-time guard: the write counter and read address must be able
  // to span a whole bank.
  generate
    if (NPIX > (1 << AW)) begin : g_aw_check
      $error("overlay_bank_ctrl: NPIX does not fit in AW bits");
    end
  endgenerate

  // Pixel banks. Not reset: contents survive iRST by design.
  logic [23:0] bank0_q [0:NPIX-1];
  logic [23:0] bank1_q [0:NPIX-1];

  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic          front_q,   front_d;
  logic          swap_q,    swap_d;
  logic          err_q,     err_d;
  logic [23:0]   rd_data_q, rd_data_d;

  logic w_accept;
  logic w_cnt_last;
  logic w_len_err;
  logic w_addr_ok;

  assign w_accept   = iWR_VALID && (state_q == S_FILL);
  assign w_cnt_last = (wr_cnt_q == LAST_IDX);

`ifdef OVL_LEN_CHECK_EN
  // iWR_LAST must coincide exactly with the final pixel position.
  assign w_len_err  = w_accept && (iWR_LAST != w_cnt_last);
`else
  logic w_unused_last;
  assign w_unused_last = iWR_LAST;
  assign w_len_err     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control: fill counter, FILL/PEND state and bank selection
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    front_d  = front_q;
    swap_d   = 1'b0;
    err_d    = 1'b0;

    if (w_accept) begin
      if (w_len_err) begin
        // Abandon the image; the next beat restarts at position 0.
        wr_cnt_d = '0;
        err_d    = 1'b1;
      end else if (w_cnt_last) begin
        wr_cnt_d = '0;
        state_d  = S_PEND;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // Frame start is only honoured with a complete image waiting; in FILL
    // it is ignored, including on the edge that accepts the final pixel.
    if ((state_q == S_PEND) && iFRAME_START) begin
      front_d = ~front_q;
      state_d = S_FILL;
      swap_d  = 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_FILL;
      wr_cnt_q <= '0;
      front_q  <= 1'b0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      front_q  <= front_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write path: the loader only ever touches the back bank (~front).
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (w_accept) begin
      if (front_q) begin
        bank0_q[wr_cnt_q] <= iWR_DATA;
      end else begin
        bank1_q[wr_cnt_q] <= iWR_DATA;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path: registered front-bank read. front_q is sampled before it
  // flips, so a read on the swap edge still returns the old bank.
  // --------------------------------------------------------------------------
  assign w_addr_ok = ({1'b0, iRD_ADDR} < NPIX_EXT);

  always_comb begin
    rd_data_d = 24'h0;
    if (w_addr_ok) begin
      rd_data_d = front_q ? bank1_q[iRD_ADDR] : bank0_q[iRD_ADDR];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_data_q <= 24'h0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign oWR_READY   = (state_q == S_FILL);
  assign oPENDING    = (state_q == S_PEND);
  assign oFRONT_BANK = front_q;
  assign oSWAP       = swap_q;
  assign oERR        = err_q;
  assign oRD_DATA    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_overlay_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_overlay_bank_ctrl
//  Description : Self-checking bench for overlay_bank_ctrl. A driver applies
//                directed and random stimulus and, on each active edge,
//                advances a behavioural image/bank model and queues the
//                expected outputs. A separate monitor pops and compares them
//                one step after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_overlay_bank_ctrl;

  localparam int NPIX = 100;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iWR_VALID = 1'b0;
  logic [23:0] iWR_DATA = 24'h0;
  logic        iWR_LAST = 1'b0;
  logic        iFRAME_START = 1'b0;
  logic [6:0]  iRD_ADDR = 7'h0;
  logic        oWR_READY;
  logic [23:0] oRD_DATA;
  logic        oFRONT_BANK;
  logic        oSWAP;
  logic        oPENDING;
  logic        oERR;

  overlay_bank_ctrl dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iWR_VALID    (iWR_VALID),
    .iWR_DATA     (iWR_DATA),
    .iWR_LAST     (iWR_LAST),
    .oWR_READY    (oWR_READY),
    .iFRAME_START (iFRAME_START),
    .iRD_ADDR     (iRD_ADDR),
    .oRD_DATA     (oRD_DATA),
    .oFRONT_BANK  (oFRONT_BANK),
    .oSWAP        (oSWAP),
    .oPENDING     (oPENDING),
    .oERR         (oERR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: two images, the index of the displayed one, how many
  // pixels of the incoming image have arrived and whether a complete image
  // is waiting. m_known marks bank entries that have ever been written, so
  // never-initialised RAM is not compared.
  // --------------------------------------------------------------------------
  logic [23:0] m_bank  [2][NPIX];
  bit          m_known [2][NPIX];
  int          m_front = 0;
  int          m_count = 0;
  bit          m_pend  = 1'b0;

  typedef struct {
    bit          chk_rd;
    logic [23:0] rd;
    bit          ready;
    bit          pend;
    bit          front;
    bit          swap;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_edge();
    exp_t e;
    if (iRST) begin
      m_front = 0;
      m_count = 0;
      m_pend  = 1'b0;
      e = '{chk_rd: 1'b1, rd: 24'h0, ready: 1'b1, pend: 1'b0,
            front: 1'b0, swap: 1'b0, err: 1'b0};
    end else begin
      e.swap = 1'b0;
      e.err  = 1'b0;
      if (int'(iRD_ADDR) >= NPIX) begin
        e.chk_rd = 1'b1;
        e.rd     = 24'h0;
      end else begin
        e.chk_rd = m_known[m_front][iRD_ADDR];
        e.rd     = m_bank[m_front][iRD_ADDR];
      end
      if (iWR_VALID && !m_pend) begin
        m_bank[1-m_front][m_count]  = iWR_DATA;
        m_known[1-m_front][m_count] = 1'b1;
`ifdef OVL_LEN_CHECK_EN
        if (iWR_LAST != (m_count == NPIX-1)) begin
          e.err   = 1'b1;
          m_count = 0;
        end else
`endif
        if (m_count == NPIX-1) begin
          m_count = 0;
          m_pend  = 1'b1;
        end else begin
          m_count = m_count + 1;
        end
      end else if (m_pend && iFRAME_START) begin
        m_front = 1 - m_front;
        m_pend  = 1'b0;
        e.swap  = 1'b1;
      end
      e.ready = !m_pend;
      e.pend  = m_pend;
      e.front = (m_front != 0);
    end
    exp_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one expectation per active edge, compared just after it.
  // --------------------------------------------------------------------------
  task automatic chk(string name, logic [23:0] act, logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge iCLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_rd) chk("rd_data", oRD_DATA, mon_e.rd);
      chk("wr_ready",   {23'h0, oWR_READY},   {23'h0, mon_e.ready});
      chk("pending",    {23'h0, oPENDING},    {23'h0, mon_e.pend});
      chk("front_bank", {23'h0, oFRONT_BANK}, {23'h0, mon_e.front});
      chk("swap",       {23'h0, oSWAP},       {23'h0, mon_e.swap});
      chk("err",        {23'h0, oERR},        {23'h0, mon_e.err});
    end
  end

  // --------------------------------------------------------------------------
  // Driver: inputs change on the falling edge; the model advances on the
  // rising edge using the same input values the DUT samples.
  // --------------------------------------------------------------------------
  task automatic step(bit rst, bit v, logic [23:0] d, bit last, bit fs,
                      logic [6:0] a);
    iRST         = rst;
    iWR_VALID    = v;
    iWR_DATA     = d;
    iWR_LAST     = last;
    iFRAME_START = fs;
    iRD_ADDR     = a;
    @(posedge iCLK);
    model_edge();
    @(negedge iCLK);
  endtask

  function automatic logic [6:0] raddr();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic idle(int n, bit fs_last);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 24'h0, 1'b0, fs_last && (k == n-1), raddr());
    end
  endtask

  task automatic stream(int n, int base, int last_at, int fs_at);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 24'(base + k), (k == last_at), (k == fs_at), raddr());
    end
  endtask

  bit prev_fs;
  bit fs;
  bit flip;

  initial begin
    // Reset state, then reset in the middle of an image at pixel 37.
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 7'd0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 7'd0);
    stream(37, 24'h100, -1, -1);
    step(1'b1, 1'b1, 24'h5A5A5A, 1'b0, 1'b0, 7'd3);
    idle(2, 1'b0);

    // Full fill with data=index, 20 idle cycles in PEND, swap, read addr 57.
    stream(NPIX, 0, NPIX-1, -1);
    idle(20, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 7'd57);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 7'd57);

    // Final pixel coincides with frame start: no swap until the next one.
    stream(NPIX, 24'h2000, NPIX-1, NPIX-1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Backpressure: beat held through PEND, accepted after the swap.
    stream(NPIX, 24'h3000, NPIX-1, -1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 7'd0);
    step(1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b1, 7'd0);
    step(1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 7'd0);
    stream(NPIX-1, 24'h4001, NPIX-2, -1);

    // Out-of-range reads.
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 7'd100);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 7'd127);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 7'd99);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Length check: iWR_LAST on pixel 50, then a normal image.
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 7'd0);
    stream(50, 24'h5000, 49, -1);
    stream(NPIX, 24'h6000, NPIX-1, -1);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Random traffic; iWR_LAST follows the model's pixel position with an
    // occasional deliberate error, frame starts never back to back.
    prev_fs = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      fs      = !prev_fs && ($urandom_range(0, 15) == 0);
      flip    = ($urandom_range(0, 199) == 0);
      prev_fs = fs;
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 3) != 0),
           24'($urandom),
           (m_count == NPIX-1) ^ flip,
           fs,
           raddr());
    end

    idle(3, 1'b0);
    @(posedge iCLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/overlay_bank_ctrl.md
# overlay_bank_ctrl

Ping-pong controller for the 10×10 RGB overlay image shown at the centre of the display.
- Owns two 24-bit pixel banks.
- Accepts a raster-ordered pixel stream from a loader into the back bank.
- Serves registered reads from the front bank to the display overlay.
- Swaps banks only at a frame boundary, so the display never shows a partially written image.

## Interface
Parameters:
- WIDTH, 10, overlay width in pixels
- HEIGHT, 10, overlay height in pixels
- NPIX, WIDTH*HEIGHT (100), pixels per bank
- AW, 7, address width (ceil(log2(NPIX)))

Ports:
- Clocking and reset: one clock, `iCLK`; reset `iRST` is asynchronous and active-high.
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- iWR_VALID  in  1  loader pixel valid
- iWR_DATA  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- iWR_LAST  in  1  marks final pixel of an image
- oWR_READY  out  1  controller can accept a pixel
- iFRAME_START  in  1  one-cycle pulse at start of each display frame (vertical blank)
- iRD_ADDR  in  AW  display read address, y*WIDTH+x
- oRD_DATA  out  24  front-bank pixel, registered
- oFRONT_BANK  out  1  index of bank currently displayed
- oSWAP  out  1  one-cycle pulse after a bank swap
- oPENDING  out  1  back bank full, waiting for frame boundary
- oERR  out  1  one-cycle pulse on image length error

## Operation
State machine has two states, FILL and PEND.

- **FILL:**
  - oWR_READY=1.
  - A beat is accepted when iWR_VALID && oWR_READY. It writes iWR_DATA to back bank (~oFRONT_BANK) at wr_cnt, then wr_cnt increments.
  - Accepting the beat with wr_cnt==NPIX-1 sets wr_cnt to 0 and moves to PEND.
  - iFRAME_START in FILL is ignored; the front bank is unchanged.
- **PEND:**
  - oWR_READY=0 and oPENDING=1; loader beats are stalled, not dropped.
  - On iFRAME_START: oFRONT_BANK toggles, state goes to FILL, and oSWAP pulses on the following cycle.
- **Read path:**
  - oRD_DATA <= bank[oFRONT_BANK][iRD_ADDR] on every clock.
  - An address ≥ NPIX returns 24'h0.
  - Reads are never stalled by writes, because the writer only ever touches the back bank.
- **Reset:**
  - Asserting iRST at any time, including mid-fill, forces FILL with wr_cnt=0 and oFRONT_BANK=0. Any partial image is abandoned.
  - Bank RAM contents are not cleared.
- **Width rules:** wr_cnt is AW bits and never exceeds NPIX-1. The WIDTH×HEIGHT product must fit in AW bits.

## Timing
- Reset values: oWR_READY=1, oRD_DATA=0, oFRONT_BANK=0, oSWAP=0, oPENDING=0, oERR=0.
- Read latency: 1 cycle, from iRD_ADDR to oRD_DATA.
- Write acceptance:
  - Single cycle; one pixel per clock sustained while in FILL.
  - oWR_READY drops in the cycle after the NPIX-th pixel is accepted.
- Swap edge:
  - The clock edge sampling iFRAME_START in PEND flips oFRONT_BANK.
  - A read sampled on that same edge uses the old bank; reads on later edges use the new bank.
  - oSWAP is high for exactly the next cycle.
  - oWR_READY returns high in the cycle after the swap edge.
- Final write coinciding with iFRAME_START: the controller is still in FILL on that edge, so there is no swap. The swap occurs at the next iFRAME_START.
- iFRAME_START pulses closer than 1 cycle apart are not supported.

## Configuration
- **OVL_LEN_CHECK_EN defined:** the controller enforces image length.
  - If iWR_LAST is set on an accepted beat with wr_cnt≠NPIX-1, or clear on the beat with wr_cnt==NPIX-1:
    - oERR pulses for 1 cycle;
    - wr_cnt resets to 0 and the state stays FILL;
    - the image is discarded, with no transition to PEND.
- **Not defined:** iWR_LAST is ignored, oERR is tied 0, and the fill completes purely on count NPIX.

## Test plan
- **Reset state:** assert iRST mid-fill at pixel 37 → all outputs at reset values; a new stream fills from address 0 of bank 1.
- **Full fill and swap:**
  - Stimulus: stream 100 pixels with data=index and iWR_LAST on the 100th; pulse iFRAME_START 20 cycles later.
  - Before the swap: oPENDING=1 and oWR_READY=0 for those 20 cycles.
  - At the swap: oFRONT_BANK goes 0→1 and oSWAP pulses once.
  - After the swap: reading addr 57 returns 24'h000039 one cycle later.
- **Boundary coincidence:** final pixel accepted on the same edge as iFRAME_START → no swap; swap on the next iFRAME_START.
- **Backpressure:** hold iWR_VALID=1 while PEND → no write occurs, and the front bank data at addr 0 is unchanged. After the swap, the held beat is accepted into the new back bank at address 0.
- **Out-of-range read:** iRD_ADDR=100 and 127 → oRD_DATA=0.
- **Length check (with OVL_LEN_CHECK_EN):**
  - iWR_LAST on pixel 50 → oERR pulses once, there is no PEND, and the next 100-pixel image fills and swaps normally.
  - Without the macro: the same stimulus gives no oERR, and the fill completes after 100 beats.
